// File: rtl/ws2812_pkg.sv
// ============================================================================
// Module  : ws2812_pkg
// Brief   : Shared timing defaults, state encoding and colour helpers for the
//           5-LED WS2812 serialiser.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ws2812_pkg;

    localparam int c_t_bit        = 62;
    localparam int c_t0h          = 20;
    localparam int c_t1h          = 40;
    localparam int c_t_reset      = 3000;
    localparam int c_num_leds     = 5;
    localparam int c_bits_per_led = 24;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        ALTO   = 2'd1,
        BAIXO  = 2'd2,
        LATCH  = 2'd3
    } state_t;

    function automatic logic [23:0] grb_reorder(input logic [23:0] rgb);
        return {rgb[15:8], rgb[23:16], rgb[7:0]};
    endfunction

    // (c * (b + 1)) >> 8; the product never exceeds 16 bits
    function automatic logic [7:0] scale_channel(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] prod;
        prod = {8'd0, c} * ({8'd0, b} + 16'd1);
        return prod[15:8];
    endfunction

endpackage

`default_nettype wire

// File: rtl/ws2812_bit_tx.sv
// ============================================================================
// Module  : ws2812_bit_tx
// Brief   : Emits one WS2812 bit waveform (high phase, then low phase) per
//           start request; 'last' flags the final low cycle so the next bit
//           can start without a gap.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ws2812_bit_tx
    import ws2812_pkg::*;
#(
    parameter int T_BIT = c_t_bit,
    parameter int T0H   = c_t0h,
    parameter int T1H   = c_t1h,
    parameter int CW    = $clog2(c_t_reset + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic bit_val,
    output logic dout,
    output logic last
);

    localparam logic [CW-1:0] c_t0h_m1 = CW'(T0H - 1);
    localparam logic [CW-1:0] c_t1h_m1 = CW'(T1H - 1);
    localparam logic [CW-1:0] c_t0l_m1 = CW'(T_BIT - T0H - 1);
    localparam logic [CW-1:0] c_t1l_m1 = CW'(T_BIT - T1H - 1);

    state_t          r_phase;
    state_t          w_phase_nx;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nx;
    logic            r_bit;
    logic            w_bit_nx;
    logic            r_dout;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_phase <= OCIOSO;
            r_cnt   <= '0;
            r_bit   <= 1'b0;
            r_dout  <= 1'b0;
        end else begin
            r_phase <= w_phase_nx;
            r_cnt   <= w_cnt_nx;
            r_bit   <= w_bit_nx;
            r_dout  <= (w_phase_nx == ALTO);
        end
    end

    always_comb begin
        w_phase_nx = r_phase;
        w_cnt_nx   = r_cnt;
        w_bit_nx   = r_bit;
        last       = 1'b0;
        case (r_phase)
            ALTO: begin
                if (r_cnt == '0) begin
                    w_phase_nx = BAIXO;
                    w_cnt_nx   = r_bit ? c_t1l_m1 : c_t0l_m1;
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end
            BAIXO: begin
                if (r_cnt == '0) begin
                    last       = 1'b1;
                    w_phase_nx = OCIOSO;
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end
            default: w_phase_nx = OCIOSO;
        endcase
        // A new bit may begin from idle or straight out of the final low cycle
        if (start && ((r_phase == OCIOSO) || last)) begin
            w_phase_nx = ALTO;
            w_bit_nx   = bit_val;
            w_cnt_nx   = bit_val ? c_t1h_m1 : c_t0h_m1;
        end
    end

    assign dout = r_dout;

endmodule

`default_nettype wire

// File: rtl/ws2812_driver_5.sv
// ============================================================================
// Module  : ws2812_driver_5
// Brief   : Serialises five 24-bit RRGGBB colours onto a WS2812 data line
//           (GRB, MSB first, led0 first), followed by a low latch period.
//           Optional macro BRILHO_EN adds an 8-bit global brightness input.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ws2812_driver_5
    import ws2812_pkg::*;
#(
    parameter int T_BIT    = c_t_bit,
    parameter int T0H      = c_t0h,
    parameter int T1H      = c_t1h,
    parameter int T_RESET  = c_t_reset,
    parameter int NUM_LEDS = c_num_leds
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        iniciar,
`ifdef BRILHO_EN
    input  logic [7:0]  brilho,
`endif
    input  logic [23:0] led0,
    input  logic [23:0] led1,
    input  logic [23:0] led2,
    input  logic [23:0] led3,
    input  logic [23:0] led4,
    output logic        dout,
    output logic        ocupado,
    output logic        pronto
);

    localparam int              CW           = $clog2(T_RESET + 1);
    localparam int              c_frame_bits = c_num_leds * c_bits_per_led;
    localparam logic [CW-1:0]   c_reset_m1   = CW'(T_RESET - 1);
    localparam logic [4:0]      c_last_bit   = 5'(c_bits_per_led - 1);
    localparam logic [2:0]      c_last_led   = 3'(NUM_LEDS - 1);

    if (!((T0H > 0) && (T0H < T1H) && (T1H < T_BIT)) || (T_RESET < 1) ||
        (NUM_LEDS != c_num_leds)) begin : g_param_check
        $error("ws2812_driver_5: illegal timing or LED-count parameters");
    end

    logic [23:0]             w_rgb [c_num_leds];
    logic [c_frame_bits-1:0] w_frame;

    assign w_rgb[0] = led0;
    assign w_rgb[1] = led1;
    assign w_rgb[2] = led2;
    assign w_rgb[3] = led3;
    assign w_rgb[4] = led4;

    for (genvar i = 0; i < c_num_leds; i++) begin : g_led
`ifdef BRILHO_EN
        assign w_frame[c_frame_bits-1-c_bits_per_led*i -: c_bits_per_led] =
            grb_reorder({scale_channel(w_rgb[i][23:16], brilho),
                         scale_channel(w_rgb[i][15:8],  brilho),
                         scale_channel(w_rgb[i][7:0],   brilho)});
`else
        assign w_frame[c_frame_bits-1-c_bits_per_led*i -: c_bits_per_led] =
            grb_reorder(w_rgb[i]);
`endif
    end

    // Frame FSM: ALTO covers the whole bit stream; per-bit high/low phasing
    // lives in the bit transmitter.
    state_t                  r_state;
    state_t                  w_state_nx;
    logic [CW-1:0]           r_cnt;
    logic [CW-1:0]           w_cnt_nx;
    logic [4:0]              r_bit_cnt;
    logic [4:0]              w_bit_cnt_nx;
    logic [2:0]              r_led_cnt;
    logic [2:0]              w_led_cnt_nx;
    logic [c_frame_bits-1:0] r_shift;
    logic [c_frame_bits-1:0] w_shift_nx;
    logic                    r_ocupado;
    logic                    r_pronto;
    logic                    w_start;
    logic                    w_bit_val;
    logic                    w_bit_last;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= OCIOSO;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_led_cnt <= '0;
            r_shift   <= '0;
            r_ocupado <= 1'b0;
            r_pronto  <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_bit_cnt <= w_bit_cnt_nx;
            r_led_cnt <= w_led_cnt_nx;
            r_shift   <= w_shift_nx;
            r_ocupado <= (w_state_nx != OCIOSO);
            r_pronto  <= (r_state == LATCH) && (w_state_nx == OCIOSO);
        end
    end

    // The shadow holds the bits still to be sent, next one at the MSB
    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_bit_cnt_nx = r_bit_cnt;
        w_led_cnt_nx = r_led_cnt;
        w_shift_nx   = r_shift;
        w_start      = 1'b0;
        w_bit_val    = r_shift[c_frame_bits-1];
        case (r_state)
            OCIOSO: begin
                if (iniciar) begin
                    w_state_nx   = ALTO;
                    w_start      = 1'b1;
                    w_bit_val    = w_frame[c_frame_bits-1];
                    w_shift_nx   = {w_frame[c_frame_bits-2:0], 1'b0};
                    w_bit_cnt_nx = '0;
                    w_led_cnt_nx = '0;
                end
            end
            ALTO: begin
                if (w_bit_last) begin
                    if ((r_bit_cnt == c_last_bit) && (r_led_cnt == c_last_led)) begin
                        w_state_nx = LATCH;
                        w_cnt_nx   = c_reset_m1;
                    end else begin
                        w_start    = 1'b1;
                        w_shift_nx = {r_shift[c_frame_bits-2:0], 1'b0};
                        if (r_bit_cnt == c_last_bit) begin
                            w_bit_cnt_nx = '0;
                            w_led_cnt_nx = r_led_cnt + 3'd1;
                        end else begin
                            w_bit_cnt_nx = r_bit_cnt + 5'd1;
                        end
                    end
                end
            end
            LATCH: begin
                if (r_cnt == '0) begin
                    w_state_nx = OCIOSO;
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end
            default: w_state_nx = OCIOSO;
        endcase
    end

    ws2812_bit_tx #(
        .T_BIT (T_BIT),
        .T0H   (T0H),
        .T1H   (T1H),
        .CW    (CW)
    ) u_bit_tx (
        .clock   (clock),
        .reset   (reset),
        .start   (w_start),
        .bit_val (w_bit_val),
        .dout    (dout),
        .last    (w_bit_last)
    );

    assign ocupado = r_ocupado;
    assign pronto  = r_pronto;

endmodule

`default_nettype wire

// File: tb/tb_ws2812_driver_5.sv
// ============================================================================
// Module  : tb_ws2812_driver_5
// Brief   : Directed bench for ws2812_driver_5: table of frames decoded from
//           the waveform, plus held-start, mid-frame-start and reset sequences.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ws2812_driver_5;

    localparam int c_bit    = 62;
    localparam int c_nbits  = 120;
    localparam int c_latch  = 3000;
    localparam int c_busy   = c_nbits * c_bit + c_latch;
    localparam int c_period = c_busy + 1;

    logic        clock   = 1'b0;
    logic        reset   = 1'b1;
    logic        iniciar = 1'b0;
    logic [23:0] led0 = '0, led1 = '0, led2 = '0, led3 = '0, led4 = '0;
`ifdef BRILHO_EN
    logic [7:0]  brilho = 8'hFF;
`endif
    logic        dout;
    logic        ocupado;
    logic        pronto;

    always #5 clock = ~clock;

    ws2812_driver_5 dut (
        .clock   (clock),
        .reset   (reset),
        .iniciar (iniciar),
`ifdef BRILHO_EN
        .brilho  (brilho),
`endif
        .led0    (led0),
        .led1    (led1),
        .led2    (led2),
        .led3    (led3),
        .led4    (led4),
        .dout    (dout),
        .ocupado (ocupado),
        .pronto  (pronto)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [119:0] leds;
        logic [7:0]   br;
        logic [119:0] exp_grb;
        bit           disturb;
    } vec_t;

    task automatic chk(input string nm, input logic [119:0] act, input logic [119:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Starts a frame and checks every cycle against the ideal waveform for exp_bits
    task automatic run_frame(input logic [119:0] leds, input logic [119:0] exp_bits,
                             input bit disturb, input string nm);
        int           hc [c_nbits];
        int           wave_err;
        int           ocu_err;
        int           pr_err;
        logic [119:0] got;
        logic         exp_d;
        foreach (hc[i]) hc[i] = 0;
        wave_err = 0;
        ocu_err  = 0;
        pr_err   = 0;
        @(negedge clock);
        {led0, led1, led2, led3, led4} = leds;
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        for (int t = 0; t < c_busy; t++) begin
            if (t < c_nbits * c_bit) begin
                exp_d = ((t % c_bit) < (exp_bits[119 - t / c_bit] ? 40 : 20));
                if (dout) hc[t / c_bit]++;
            end else begin
                exp_d = 1'b0;
            end
            if (dout !== exp_d) wave_err++;
            if (ocupado !== 1'b1) ocu_err++;
            if (pronto !== 1'b0) pr_err++;
            if (disturb && t == 500) begin
                iniciar = 1'b1;
                {led0, led1, led2, led3, led4} = ~leds;
            end
            if (disturb && t == 501) iniciar = 1'b0;
            @(negedge clock);
        end
        for (int i = 0; i < c_nbits; i++) got[119 - i] = (hc[i] > 30);
        chk({nm, " decoded bits"}, got, exp_bits);
        chk({nm, " waveform error cycles"}, 120'(wave_err), 0);
        chk({nm, " ocupado low cycles"}, 120'(ocu_err), 0);
        chk({nm, " early pronto cycles"}, 120'(pr_err), 0);
        chk({nm, " pronto at end"}, 120'(pronto), 1);
        chk({nm, " ocupado at end"}, 120'(ocupado), 0);
        chk({nm, " dout at end"}, 120'(dout), 0);
        @(negedge clock);
        chk({nm, " pronto one cycle"}, 120'(pronto), 0);
    endtask

    task automatic hold_test();
        int   rises [$];
        int   npr;
        int   derr;
        logic prev;
        npr  = 0;
        derr = 0;
        prev = 1'b0;
        @(negedge clock);
        {led0, led1, led2, led3, led4} = {24'h0000FF, 96'h0};
        iniciar = 1'b1;
        for (int t = 0; t < 4 * c_period && rises.size() < 4; t++) begin
            @(negedge clock);
            if (ocupado && !prev) begin
                rises.push_back(t);
                if (dout !== 1'b1) derr++;
            end
            if (pronto) npr++;
            prev = ocupado;
        end
        iniciar = 1'b0;
        chk("held start: frame starts seen", 120'(rises.size()), 4);
        chk("held start: pronto pulses", 120'(npr), 3);
        chk("held start: dout low at frame start", 120'(derr), 0);
        for (int i = 1; i < 4; i++)
            chk($sformatf("held start: gap %0d", i),
                120'((i < rises.size()) ? rises[i] - rises[i-1] : -1), c_period);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic reset_test();
        int perr;
        perr = 0;
        @(negedge clock);
        {led0, led1, led2, led3, led4} = {24'hFFFFFF, 96'h0};
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        repeat (2000) @(negedge clock);
        chk("mid-frame: ocupado before reset", 120'(ocupado), 1);
        reset = 1'b1;
        @(negedge clock);
        chk("mid-frame reset: dout", 120'(dout), 0);
        chk("mid-frame reset: ocupado", 120'(ocupado), 0);
        chk("mid-frame reset: pronto", 120'(pronto), 0);
        reset = 1'b0;
        repeat (5) begin
            @(negedge clock);
            if (pronto !== 1'b0 || ocupado !== 1'b0) perr++;
        end
        chk("after reset: idle cycles with activity", 120'(perr), 0);
        run_frame({24'h123456, 24'h0, 24'hABCDEF, 24'h0, 24'h808080},
                  {24'h341256, 24'h0, 24'hCDABEF, 24'h0, 24'h808080}, 1'b0, "post-reset frame");
    endtask

    initial begin
        vec_t vecs [$];
        vecs.push_back('{leds: {24'hFF0000, 96'h0}, br: 8'hFF,
                         exp_grb: {24'h00FF00, 96'h0}, disturb: 1'b1});
        vecs.push_back('{leds: {96'h0, 24'h00FF01}, br: 8'hFF,
                         exp_grb: {96'h0, 24'hFF0001}, disturb: 1'b0});
`ifdef BRILHO_EN
        vecs.push_back('{leds: {24'hFF8040, 96'h0}, br: 8'd127,
                         exp_grb: {24'h407F20, 96'h0}, disturb: 1'b0});
`endif

        repeat (3) @(negedge clock);
        chk("reset: dout", 120'(dout), 0);
        chk("reset: ocupado", 120'(ocupado), 0);
        chk("reset: pronto", 120'(pronto), 0);
        reset = 1'b0;

        for (int v = 0; v < vecs.size(); v++) begin
`ifdef BRILHO_EN
            brilho = vecs[v].br;
`endif
            run_frame(vecs[v].leds, vecs[v].exp_grb, vecs[v].disturb, $sformatf("vector %0d", v));
        end

        hold_test();
        reset_test();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
